// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Covers funct3 encodings, FSM state type and byte-enable width.
package dmem_pkg;

    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Store lane enables and data replication, and load shift/extension.
// The output is meaningful only for a legal, aligned request.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]      i_fn3,
    input  logic [1:0]      i_addr_lo,
    input  logic [31:0]     i_wdata,
    input  logic [31:0]     i_rword,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_wdata,
    output logic [31:0]     o_rdata
);

    logic [31:0] w_shift;

    assign w_shift = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be    = '0;
        o_wdata = i_wdata;
        o_rdata = '0;
        case (i_fn3)
            FN3_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            end
            FN3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h0, w_shift[7:0]};
            end
            FN3_H: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            end
            FN3_HU: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'h0, w_shift[15:0]};
            end
            FN3_W: begin
                o_be    = '1;
                o_rdata = w_shift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte/half/word stores and extended loads with error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_fn3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_fn3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]   w_idx;
    logic [31:0]     w_rword;
    logic [BE_W-1:0] w_be;
    logic [31:0]     w_wdata_rep;
    logic [31:0]     w_load;
    logic            w_misal;
    logic            w_oor;
    logic            w_bad_fn3;
    logic            w_err;
    logic            w_access;

    assign w_idx   = r_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_fn3     (r_fn3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_load)
    );

    always_comb begin
        w_misal = 1'b0;
        case (r_fn3)
            FN3_H, FN3_HU: w_misal = r_addr[0];
            FN3_W:         w_misal = |r_addr[1:0];
            default:       w_misal = 1'b0;
        endcase
    end

    assign w_oor     = {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign w_bad_fn3 = r_we ? !(r_fn3 inside {FN3_B, FN3_H, FN3_W})
                            : !(r_fn3 inside {FN3_B, FN3_H, FN3_W, FN3_BU, FN3_HU});
    assign w_err     = w_misal | w_oor | w_bad_fn3;
    assign w_access  = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    // Array is deliberately not reset; an aborted request never reaches here
    // because reset forces the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_err) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_fn3   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_fn3   <= req_fn3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 4'(LATENCY);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_err   <= w_err;
                        r_rdata <= (w_err || r_we) ? '0 : w_load;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = nrst && (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written stall and
// reset sequences, then random traffic against a byte-array memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LAT     = 1;
    localparam int unsigned NBYTES  = 4 * DEPTH;
    localparam logic [2:0]  F_B  = 3'b000;
    localparam logic [2:0]  F_H  = 3'b001;
    localparam logic [2:0]  F_W  = 3'b010;
    localparam logic [2:0]  F_BU = 3'b100;
    localparam logic [2:0]  F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_fn3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [NBYTES];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_fn3   (req_fn3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [2:0]  fn3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(bit we, logic [2:0] fn3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] er, bit ee);
        vec_t v;
        v.we = we; v.fn3 = fn3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory is a flat byte array; access size, alignment and
    // legality are derived directly from funct3 and the byte address.
    task automatic ref_access(input bit we, input logic [2:0] fn3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int unsigned sz;
        bit legal;
        logic [31:0] val;
        case (fn3)
            F_B, F_BU: sz = 1;
            F_H, F_HU: sz = 2;
            F_W:       sz = 4;
            default:   sz = 0;
        endcase
        legal = we ? (fn3 inside {F_B, F_H, F_W}) : (sz != 0);
        err = !legal || (addr >= 32'(NBYTES)) || ((addr % sz) != 0);
        rd = '0;
        if (!err) begin
            if (we) begin
                for (int unsigned i = 0; i < sz; i++) ref_mem[addr + i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int unsigned i = 0; i < sz; i++) val |= 32'(ref_mem[addr + i]) << (8*i);
                if ((fn3 == F_B || fn3 == F_H) && val[8*sz-1]) val |= 32'hFFFF_FFFF << (8*sz);
                rd = val;
            end
        end
    endtask

    task automatic issue(input bit we, input logic [2:0] fn3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_we = we; req_fn3 = fn3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic await_rsp();
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(LAT + 1));
    endtask

    task automatic run_op(input string name, input bit we, input logic [2:0] fn3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] er, input bit ee, input int stall);
        rsp_ready = (stall == 0);
        issue(we, fn3, addr, wd);
        await_rsp();
        check({name, "_rdata"}, rsp_rdata, er);
        check({name, "_err"}, 32'(rsp_err), 32'(ee));
        check({name, "_req_ready_in_resp"}, 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({name, "_stall_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "_stall_rdata"}, rsp_rdata, er);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        bit          ee;
        logic [31:0] held;
        bit          we;
        logic [2:0]  fn3;
        logic [31:0] addr, wd;
        int          r, stall;

        vecs[0]  = mk(1, F_W,    32'h10, 32'hDEADBEEF, 32'h0,        0);
        vecs[1]  = mk(0, F_W,    32'h10, 32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(0, F_B,    32'h13, 32'h0,        32'hFFFFFFDE, 0);
        vecs[3]  = mk(0, F_BU,   32'h13, 32'h0,        32'h000000DE, 0);
        vecs[4]  = mk(0, F_H,    32'h12, 32'h0,        32'hFFFFDEAD, 0);
        vecs[5]  = mk(0, F_HU,   32'h10, 32'h0,        32'h0000BEEF, 0);
        vecs[6]  = mk(1, F_B,    32'h11, 32'h55,       32'h0,        0);
        vecs[7]  = mk(0, F_W,    32'h10, 32'h0,        32'hDEAD55EF, 0);
        vecs[8]  = mk(1, F_H,    32'h12, 32'h1234,     32'h0,        0);
        vecs[9]  = mk(0, F_W,    32'h10, 32'h0,        32'h123455EF, 0);
        vecs[10] = mk(0, F_W,    32'h12, 32'h0,        32'h0,        1);
        vecs[11] = mk(0, F_H,    32'h13, 32'h0,        32'h0,        1);
        vecs[12] = mk(1, F_BU,   32'h10, 32'hFFFFFFFF, 32'h0,        1);
        vecs[13] = mk(0, F_W,    NBYTES, 32'h0,        32'h0,        1);
        vecs[14] = mk(0, 3'b011, 32'h10, 32'h0,        32'h0,        1);
        vecs[15] = mk(1, F_H,    32'h11, 32'hAAAA,     32'h0,        1);
        vecs[16] = mk(0, F_W,    32'h10, 32'h0,        32'h123455EF, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].fn3, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        for (int unsigned w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            ref_access(1'b1, F_W, 32'(4*w), wd, er, ee);
            run_op("init", 1'b1, F_W, 32'(4*w), wd, er, ee, 0);
        end

        // Stall in RESP with a pending request held on the input.
        rsp_ready = 1'b0;
        ref_access(1'b0, F_W, 32'h10, 32'h0, er, ee);
        issue(1'b0, F_W, 32'h10, 32'h0);
        await_rsp();
        check("stall_first_rdata", rsp_rdata, er);
        held = er;
        req_we = 1'b1; req_fn3 = F_W; req_addr = 32'h14; req_wdata = 32'hA5A5A5A5;
        req_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, held);
            check("stall_err", 32'(rsp_err), 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_drop", 32'(rsp_valid), 32'd0);
        check("hs_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("second_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        ref_access(1'b1, F_W, 32'h14, 32'hA5A5A5A5, er, ee);
        await_rsp();
        check("second_err", 32'(rsp_err), 32'd0);
        check("second_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        ref_access(1'b0, F_W, 32'h14, 32'h0, er, ee);
        run_op("after_stall_lw", 1'b0, F_W, 32'h14, 32'h0, er, ee, 0);

        // Reset during WAIT drops the store.
        issue(1'b1, F_W, 32'h20, 32'h1);
        nrst = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_valid_hold", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("midrst_idle", 32'(req_ready), 32'd1);
        ref_access(1'b0, F_W, 32'h20, 32'h0, er, ee);
        run_op("midrst_lw", 1'b0, F_W, 32'h20, 32'h0, er, ee, 0);

        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            case (r % 5)
                0: fn3 = F_B;
                1: fn3 = F_H;
                2: fn3 = F_W;
                3: fn3 = F_BU;
                default: fn3 = F_HU;
            endcase
            if (r >= 14) fn3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 19);
            if (r == 0) addr = $urandom;
            else if (r == 1) addr = 32'(NBYTES) + 32'($urandom_range(0, 7));
            else addr = 32'($urandom_range(0, NBYTES - 1));
            if (r >= 10) begin
                if (fn3 == F_W) addr[1:0] = 2'b00;
                else if (fn3 == F_H || fn3 == F_HU) addr[0] = 1'b0;
            end
            wd = $urandom;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ref_access(we, fn3, addr, wd, er, ee);
            run_op("rand", we, fn3, addr, wd, er, ee, stall);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
